// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync/blank decode and output delay line
// for a VGA pixel pipeline. All outputs come straight from flops; the decode
// is computed from the next counter values so it lines up with DrawX/DrawY.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       blank_d,
  output logic       hs_d,
  output logic       vs_d,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned CW      = 10;
  // One extra bit so range limits equal to 1024 still compare correctly.
  localparam int unsigned KW      = CW + 1;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [KW-1:0] H_ACT_K  = KW'(H_ACTIVE);
  localparam logic [KW-1:0] V_ACT_K  = KW'(V_ACTIVE);
  localparam logic [KW-1:0] HS_BEG_K = KW'(H_ACTIVE + H_FP);
  localparam logic [KW-1:0] HS_END_K = KW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [KW-1:0] VS_BEG_K = KW'(V_ACTIVE + V_FP);
  localparam logic [KW-1:0] VS_END_K = KW'(V_ACTIVE + V_FP + V_SYNC);

  // Reject geometries the 10-bit position outputs cannot represent.
  if (H_TOTAL > 1024) begin : g_bad_htotal
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_vtotal
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (PIPE_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be 0..4");
  end

  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_vc;
  logic          r_blank;
  logic          r_hs;
  logic          r_vs;
  logic          r_ls;
  logic          r_fs;
  logic [7:0]    r_fc;

  logic          w_hwrap;
  logic          w_vwrap;
  logic [CW-1:0] w_hc_nxt;
  logic [CW-1:0] w_vc_nxt;
  logic [KW-1:0] w_hc_k;
  logic [KW-1:0] w_vc_k;
  logic          w_blank_nxt;
  logic          w_hs_nxt;
  logic          w_vs_nxt;
  logic          w_ls_nxt;
  logic          w_fs_nxt;

  // Next raster position: hc wraps every line, vc advances on hc wrap.
  assign w_hwrap  = (r_hc == H_LAST);
  assign w_vwrap  = (r_vc == V_LAST);
  assign w_hc_nxt = w_hwrap ? '0 : r_hc + CW'(1);
  assign w_vc_nxt = w_hwrap ? (w_vwrap ? '0 : r_vc + CW'(1)) : r_vc;
  assign w_hc_k   = KW'(w_hc_nxt);
  assign w_vc_k   = KW'(w_vc_nxt);

  // Region decode from the next position, so registered flags match DrawX/DrawY.
  assign w_blank_nxt = (w_hc_k < H_ACT_K) && (w_vc_k < V_ACT_K);
  assign w_hs_nxt    = ((w_hc_k >= HS_BEG_K) && (w_hc_k < HS_END_K)) ? SYNC_POL : ~SYNC_POL;
  assign w_vs_nxt    = ((w_vc_k >= VS_BEG_K) && (w_vc_k < VS_END_K)) ? SYNC_POL : ~SYNC_POL;
  assign w_ls_nxt    = (w_hc_nxt == '0);
  assign w_fs_nxt    = w_ls_nxt && (w_vc_nxt == '0);

  // Counter and decode registers; reset parks on the last raster position.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hc    <= H_LAST;
      r_vc    <= V_LAST;
      r_blank <= 1'b0;
      r_hs    <= ~SYNC_POL;
      r_vs    <= ~SYNC_POL;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
      r_fc    <= 8'hFF;
    end else begin
      r_hc    <= w_hc_nxt;
      r_vc    <= w_vc_nxt;
      r_blank <= w_blank_nxt;
      r_hs    <= w_hs_nxt;
      r_vs    <= w_vs_nxt;
      r_ls    <= w_ls_nxt;
      r_fs    <= w_fs_nxt;
      if (w_fs_nxt) begin
        r_fc <= r_fc + 8'd1;
      end
    end
  end

  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign blank       = r_blank;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
  assign frame_cnt   = r_fc;

  if (PIPE_DELAY == 0) begin : g_no_delay
    assign blank_d = r_blank;
    assign hs_d    = r_hs;
    assign vs_d    = r_vs;
  end else begin : g_delay
    localparam int unsigned DW = 3 * PIPE_DELAY;
    logic [DW-1:0] r_dly;

    // Shift register of {blank,hs,vs}; low slot is one cycle old, top slot PIPE_DELAY old.
    always_ff @(posedge vga_clk) begin
      if (reset) begin
        r_dly <= {PIPE_DELAY{1'b0, ~SYNC_POL, ~SYNC_POL}};
      end else begin
        r_dly <= DW'({r_dly, r_blank, r_hs, r_vs});
      end
    end

    assign {blank_d, hs_d, vs_d} = r_dly[DW-1 -: 3];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances on a reduced raster (20x12) with
// different delay/polarity settings, checked every cycle against a position
// model, plus hand-computed counts for one frame and the frame counter wrap.
module tb_vga_timing_gen;

  localparam int HA  = 12;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 3;
  localparam int VA  = 8;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HSW + HBP;  // 20
  localparam int VT  = VA + VFP + VSW + VBP;  // 12

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       bd;
    logic       hd;
    logic       vd;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  out_t oa, ob, oc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(1'b0), .PIPE_DELAY(1)
  ) dut_a (
    .vga_clk(clk), .reset(reset), .DrawX(oa.x), .DrawY(oa.y),
    .blank(oa.blank), .hs(oa.hs), .vs(oa.vs),
    .blank_d(oa.bd), .hs_d(oa.hd), .vs_d(oa.vd),
    .line_start(oa.ls), .frame_start(oa.fs), .frame_cnt(oa.fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(1'b1), .PIPE_DELAY(0)
  ) dut_b (
    .vga_clk(clk), .reset(reset), .DrawX(ob.x), .DrawY(ob.y),
    .blank(ob.blank), .hs(ob.hs), .vs(ob.vs),
    .blank_d(ob.bd), .hs_d(ob.hd), .vs_d(ob.vd),
    .line_start(ob.ls), .frame_start(ob.fs), .frame_cnt(ob.fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(1'b0), .PIPE_DELAY(3)
  ) dut_c (
    .vga_clk(clk), .reset(reset), .DrawX(oc.x), .DrawY(oc.y),
    .blank(oc.blank), .hs(oc.hs), .vs(oc.vs),
    .blank_d(oc.bd), .hs_d(oc.hd), .vs_d(oc.vd),
    .line_start(oc.ls), .frame_start(oc.fs), .frame_cnt(oc.fc)
  );

  // Reference model: raster position plus "asserted" flags and their history.
  int mx, my, mfc;
  bit mb, mh, mv, mls, mfs;
  bit hb[4];
  bit hh[4];
  bit hv[4];
  bit mvalid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mx = HT - 1; my = VT - 1; mfc = 255;
      mb = 1'b0; mh = 1'b0; mv = 1'b0; mls = 1'b0; mfs = 1'b0;
      for (int k = 0; k < 4; k++) begin
        hb[k] = 1'b0; hh[k] = 1'b0; hv[k] = 1'b0;
      end
      mvalid = 1'b1;
    end else if (mvalid) begin
      for (int k = 3; k > 0; k--) begin
        hb[k] = hb[k-1]; hh[k] = hh[k-1]; hv[k] = hv[k-1];
      end
      hb[0] = mb; hh[0] = mh; hv[0] = mv;
      mx = (mx + 1) % HT;
      if (mx == 0) my = (my + 1) % VT;
      mls = (mx == 0);
      mfs = mls && (my == 0);
      if (mfs) mfc = (mfc + 1) % 256;
      mb = (mx < HA) && (my < VA);
      mh = (mx >= HA + HFP) && (mx < HA + HFP + HSW);
      mv = (my >= VA + VFP) && (my < VA + VFP + VSW);
    end
  end

  function automatic out_t expect_out(int pd, bit pol);
    out_t e;
    e.x     = 10'(mx);
    e.y     = 10'(my);
    e.blank = mb;
    e.hs    = mh ? pol : ~pol;
    e.vs    = mv ? pol : ~pol;
    e.bd    = (pd == 0) ? mb : hb[pd-1];
    e.hd    = ((pd == 0) ? mh : hh[pd-1]) ? pol : ~pol;
    e.vd    = ((pd == 0) ? mv : hv[pd-1]) ? pol : ~pol;
    e.ls    = mls;
    e.fs    = mfs;
    e.fc    = 8'(mfc);
    return e;
  endfunction

  task automatic chk(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got x=%0d y=%0d b/h/v=%b%b%b d=%b%b%b ls/fs=%b%b fc=%0d, expected x=%0d y=%0d b/h/v=%b%b%b d=%b%b%b ls/fs=%b%b fc=%0d",
               name, $time, act.x, act.y, act.blank, act.hs, act.vs, act.bd, act.hd, act.vd,
               act.ls, act.fs, act.fc, exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.bd, exp.hd,
               exp.vd, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("dut_a_pd1_pol0", oa, expect_out(1, 1'b0));
      chk("dut_b_pd0_pol1", ob, expect_out(0, 1'b1));
      chk("dut_c_pd3_pol0", oc, expect_out(3, 1'b0));
    end
  end

  initial begin
    int nb, nhs, nhs0, nvs, nls, nfs, cyc;
    bit found;

    // Reset for three edges, then release.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    lit("rst_x", int'(oa.x), 19);
    lit("rst_y", int'(oa.y), 11);
    lit("rst_blank", int'(oa.blank), 0);
    lit("rst_hs", int'(oa.hs), 1);
    lit("rst_vs", int'(oa.vs), 1);
    lit("rst_hs_pol1", int'(ob.hs), 0);
    lit("rst_fc", int'(oa.fc), 255);
    lit("rst_blank_d", int'(oc.bd), 0);
    reset = 1'b0;

    @(negedge clk);
    lit("first_x", int'(oa.x), 0);
    lit("first_y", int'(oa.y), 0);
    lit("first_blank", int'(oa.blank), 1);
    lit("first_ls", int'(oa.ls), 1);
    lit("first_fs", int'(oa.fs), 1);
    lit("first_fc", int'(oa.fc), 0);

    // One full frame of hand-computed region counts.
    nb = 0; nhs = 0; nhs0 = 0; nvs = 0; nls = 0; nfs = 0;
    for (int i = 0; i < HT * VT; i++) begin
      if (i > 0) @(negedge clk);
      nb   += int'(oa.blank);
      nhs  += int'(oa.hs == 1'b0);
      nhs0 += int'(oa.hs == 1'b0 && oa.y == 10'd0);
      nvs  += int'(oa.vs == 1'b0);
      nls  += int'(oa.ls);
      nfs  += int'(oa.fs);
    end
    lit("frame_blank_cnt", nb, 96);
    lit("frame_hs_cnt", nhs, 36);
    lit("line0_hs_cnt", nhs0, 3);
    lit("frame_vs_cnt", nvs, 40);
    lit("frame_ls_cnt", nls, 12);
    lit("frame_fs_cnt", nfs, 1);
    @(negedge clk);
    lit("frame2_fs", int'(oa.fs), 1);
    lit("frame2_fc", int'(oa.fc), 1);

    // Single-cycle reset in mid-frame at (5,4).
    found = 1'b0;
    for (int i = 0; i < HT * VT + 2 && !found; i++) begin
      if (oa.x == 10'd5 && oa.y == 10'd4) found = 1'b1;
      else @(negedge clk);
    end
    lit("midrst_reached", int'(found), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lit("midrst_x", int'(oa.x), 19);
    lit("midrst_y", int'(oa.y), 11);
    lit("midrst_blank_d", int'(oa.bd), 0);
    @(negedge clk);
    lit("midrst_next_x", int'(oa.x), 0);
    lit("midrst_next_y", int'(oa.y), 0);
    lit("midrst_next_fs", int'(oa.fs), 1);
    lit("midrst_next_fc", int'(oa.fc), 0);

    // Random reset pulses at random points of the raster.
    repeat (6) begin
      repeat ($urandom_range(1, 700)) @(negedge clk);
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      reset = 1'b0;
    end

    // 256 more frames: counter walks 1..255 then wraps to 0, fixed period.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    lit("wrap_start_fc", int'(oa.fc), 0);
    for (int f = 1; f <= 256; f++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!oa.fs && cyc < HT * VT + 5);
      lit("frame_period", cyc, HT * VT);
      lit("frame_cnt_seq", int'(oa.fc), f % 256);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
